// File: rtl/div_pkg.sv
// Shared types and constants for the streaming divider wrapper and its result buffering.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 4;

  localparam logic [2*DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef struct packed {
    logic [2*DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0]   remainder;
    logic                   div_zero;
  } div_result_t;

  typedef struct packed {
    logic valid;
    logic zero;
  } div_tag_t;

  function automatic div_result_t div_zero_result();
    div_result_t res;
    res.quotient  = DIV_ZERO_QUOTIENT;
    res.remainder = '0;
    res.div_zero  = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Synchronous first-word-fall-through FIFO; depth need not be a power of two.
module div_result_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    full_o  = (count_q == CntW'(DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
    rdata_o = mem_q[rd_ptr_q];

    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream flow control is expected to make this impossible.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
    else $error("div_result_fifo: push while full");

endmodule

// File: rtl/div_stream_ctrl.sv
// Valid/ready streaming wrapper around a fixed-latency pipelined divider, with a
// credit-protected result FIFO and local divide-by-zero handling.
module div_stream_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH       = DIV_WIDTH,
  parameter int unsigned DIV_LATENCY = 8,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_dividend,
  input  logic [WIDTH-1:0]     in_divisor,
  output logic [2*WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]     div_divisor,
  input  logic [2*WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]     div_remainder,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_quotient,
  output logic [WIDTH-1:0]     out_remainder,
  output logic                 out_div_zero,
  output logic                 busy
);

  if (WIDTH != DIV_WIDTH) begin : g_width_mismatch
    $error("div_stream_ctrl: WIDTH must equal div_pkg::DIV_WIDTH");
  end

  localparam int unsigned ResW  = $bits(div_result_t);
  localparam int unsigned InflW = $clog2(DIV_LATENCY + 1);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  logic [2*WIDTH-1:0]           div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0]             div_divisor_q, div_divisor_d;
  div_tag_t [DIV_LATENCY-1:0]   tag_q, tag_d;
  logic [InflW-1:0]             inflight_q, inflight_d;

  logic        accept, tag_exit, fifo_pop;
  logic        fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  div_result_t push_data, head;

  always_comb begin
    // Credit counts both in-flight ops and buffered results, so a capture always has room.
    in_ready = (32'(inflight_q) + 32'(fifo_count)) < FIFO_DEPTH;
    accept   = in_valid && in_ready;
    tag_exit = tag_q[DIV_LATENCY-1].valid;

    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    if (accept) begin
      div_dividend_d = in_dividend;
      div_divisor_d  = (in_divisor == '0) ? WIDTH'(1) : in_divisor;
    end

    tag_d[0].valid = accept;
    tag_d[0].zero  = accept && (in_divisor == '0);
    for (int i = 1; i < int'(DIV_LATENCY); i++) begin
      tag_d[i] = tag_q[i-1];
    end

    inflight_d = inflight_q;
    if (accept && !tag_exit) begin
      inflight_d = inflight_q + InflW'(1);
    end else if (!accept && tag_exit) begin
      inflight_d = inflight_q - InflW'(1);
    end

    if (tag_q[DIV_LATENCY-1].zero) begin
      push_data = div_zero_result();
    end else begin
      push_data.quotient  = div_quotient;
      push_data.remainder = div_remainder;
      push_data.div_zero  = 1'b0;
    end

    fifo_pop = !fifo_empty && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_dividend_q <= '0;
      div_divisor_q  <= WIDTH'(1);
      tag_q          <= '0;
      inflight_q     <= '0;
    end else begin
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      tag_q          <= tag_d;
      inflight_q     <= inflight_d;
    end
  end

  div_result_fifo #(
    .DATA_W (ResW),
    .DEPTH  (FIFO_DEPTH)
  ) u_result_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (tag_exit),
    .wdata_i (push_data),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    div_dividend  = div_dividend_q;
    div_divisor   = div_divisor_q;
    out_valid     = !fifo_empty;
    out_quotient  = head.quotient;
    out_remainder = head.remainder;
    out_div_zero  = head.div_zero;
    busy          = (inflight_q != '0) || !fifo_empty;
  end

endmodule

// File: tb/tb_div_stream_ctrl.sv
// Scoreboard bench for div_stream_ctrl with a behavioural fixed-latency divider.
module tb_div_stream_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned L = 8;
  localparam int unsigned D = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_dividend;
  logic [W-1:0]   in_divisor;
  logic [2*W-1:0] div_dividend;
  logic [W-1:0]   div_divisor;
  logic [2*W-1:0] div_quotient;
  logic [W-1:0]   div_remainder;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_quotient;
  logic [W-1:0]   out_remainder;
  logic           out_div_zero;
  logic           busy;

  always #5 clk = ~clk;

  div_stream_ctrl #(
    .WIDTH       (W),
    .DIV_LATENCY (L),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div_zero  (out_div_zero),
    .busy          (busy)
  );

  // Divider model: result of the current operands is sampleable L edges after they change.
  logic [2*W-1:0] mq [L-1];
  logic [W-1:0]   mr [L-1];
  always @(posedge clk) begin
    mq[0] <= (div_divisor == '0) ? 8'hFF : 8'(div_dividend / {4'b0, div_divisor});
    mr[0] <= (div_divisor == '0) ? 4'h0 : 4'(div_dividend % {4'b0, div_divisor});
    for (int i = 1; i < int'(L) - 1; i++) begin
      mq[i] <= mq[i-1];
      mr[i] <= mr[i-1];
    end
  end
  assign div_quotient  = mq[L-2];
  assign div_remainder = mr[L-2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passes = 0;
  int total  = 0;
  int stalls = 0;
  logic [12:0] exp_q [$];
  int          pop_cycles [$];
  logic [24:0] vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [12:0] golden(input logic [7:0] a, input logic [3:0] b);
    if (b == 4'd0) return {8'hFF, 4'h0, 1'b1};
    return {8'(a / {4'b0, b}), 4'(a % {4'b0, b}), 1'b0};
  endfunction

  // Monitor: every accepted result is compared against the head of the scoreboard.
  always @(negedge clk) begin
    logic [12:0] e;
    if (rst_n && out_valid && out_ready) begin
      pop_cycles.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result",
                 {out_quotient, out_remainder, out_div_zero});
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({out_quotient, out_remainder, out_div_zero}), 32'(e));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [3:0] b, input logic [12:0] e,
                      output int acc_cyc);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    acc_cyc = cyc;
    in_valid = 1'b1;
    in_dividend = a;
    in_divisor = b;
    while (!acc) begin
      acc = in_ready;
      if (acc) begin
        exp_q.push_back(e);
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
      if (!acc) begin
        n++;
        stalls++;
        if (n > 200) begin
          total++;
          $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int idx, output int acc_cyc);
    logic [24:0] v;
    v = vecs[idx];
    send(v[24:17], v[16:13], v[12:0], acc_cyc);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc, first, n_acc, n_ov, sent, n;
    logic [7:0] a;
    logic [3:0] b;
    logic [24:0] v;

    // {dividend, divisor, quotient, remainder, div_zero}
    vecs = '{
      {8'd200, 4'd7,  8'd28,  4'd4,  1'b0}, {8'd255, 4'd1,  8'd255, 4'd0,  1'b0},
      {8'd255, 4'd15, 8'd17,  4'd0,  1'b0}, {8'd100, 4'd3,  8'd33,  4'd1,  1'b0},
      {8'd0,   4'd5,  8'd0,   4'd0,  1'b0}, {8'd17,  4'd4,  8'd4,   4'd1,  1'b0},
      {8'd99,  4'd10, 8'd9,   4'd9,  1'b0}, {8'd128, 4'd9,  8'd14,  4'd2,  1'b0},
      {8'd250, 4'd13, 8'd19,  4'd3,  1'b0}, {8'd1,   4'd2,  8'd0,   4'd1,  1'b0},
      {8'd77,  4'd0,  8'd255, 4'd0,  1'b1}, {8'd64,  4'd8,  8'd8,   4'd0,  1'b0},
      {8'd181, 4'd11, 8'd16,  4'd5,  1'b0}, {8'd33,  4'd6,  8'd5,   4'd3,  1'b0},
      {8'd240, 4'd14, 8'd17,  4'd2,  1'b0}, {8'd59,  4'd12, 8'd4,   4'd11, 1'b0},
      {8'd7,   4'd7,  8'd1,   4'd0,  1'b0}, {8'd222, 4'd5,  8'd44,  4'd2,  1'b0},
      {8'd150, 4'd15, 8'd10,  4'd0,  1'b0}, {8'd3,   4'd0,  8'd255, 4'd0,  1'b1}
    };

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_div_divisor", 32'(div_divisor), 32'd1);
    check("rst_div_dividend", 32'(div_dividend), 32'd0);
    check("rst_out_fields", 32'({out_quotient, out_remainder, out_div_zero}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single op, latency and busy.
    out_ready = 1'b1;
    pop_cycles.delete();
    send(8'd200, 4'd7, {8'd28, 4'd4, 1'b0}, acc);
    while (cyc < acc + 8) begin @(posedge clk); #1; end
    check("t1_no_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_at_accept_plus_9", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("t1_busy_low_after_pop", 32'(busy), 32'd0);
    check("t1_pop_count", 32'(pop_cycles.size()), 32'd1);
    if (pop_cycles.size() > 0) check("t1_latency", 32'(pop_cycles[0] - acc), 32'd9);

    // Divide by zero.
    send(8'hAB, 4'd0, {8'hFF, 4'h0, 1'b1}, acc);
    check("t2_div_divisor_sub", 32'(div_divisor), 32'd1);
    check("t2_div_dividend", 32'(div_dividend), 32'hAB);
    wait_drain("t2");

    // Back-to-back directed vectors.
    pop_cycles.delete();
    stalls = 0;
    first = 0;
    for (int i = 0; i < 20; i++) begin
      send_vec(i, acc);
      if (i == 0) first = acc;
    end
    check("t3_no_stalls", 32'(stalls), 32'd0);
    wait_drain("t3");
    check("t3_pop_count", 32'(pop_cycles.size()), 32'd20);
    if (pop_cycles.size() == 20) begin
      check("t3_first_latency", 32'(pop_cycles[0] - first), 32'd9);
      check("t3_one_per_cycle", 32'(pop_cycles[19] - pop_cycles[0]), 32'd19);
    end

    // Fill with out_ready low, then drain.
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      v = vecs[i % 20];
      in_valid = 1'b1;
      in_dividend = v[24:17];
      in_divisor = v[16:13];
      if (in_ready) begin
        exp_q.push_back(v[12:0]);
        n_acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("t4_accepts", 32'(n_acc), 32'd16);
    check("t4_in_ready_full", 32'(in_ready), 32'd0);
    pop_cycles.delete();
    out_ready = 1'b1;
    check("t4_in_ready_pop_cycle", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("t4_in_ready_after_pop", 32'(in_ready), 32'd1);
    wait_drain("t4");
    check("t4_pop_count", 32'(pop_cycles.size()), 32'd16);

    // Reset mid-operation.
    send_vec(3, first);
    send_vec(4, acc);
    send_vec(5, acc);
    while (cyc < first + 4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_div_divisor", 32'(div_divisor), 32'd1);
    n_ov = 0;
    repeat (20) begin
      n_ov += int'(out_valid);
      @(posedge clk); #1;
    end
    check("t5_no_stale_results", 32'(n_ov), 32'd0);

    // Random traffic with backpressure.
    sent = 0;
    n = 0;
    while (sent < 1000 && n < 20000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid = ($urandom_range(0, 9) < 7);
      a = 8'($urandom);
      b = ($urandom_range(0, 99) < 5) ? 4'd0 : 4'($urandom_range(1, 15));
      in_dividend = a;
      in_divisor = b;
      if (in_valid && in_ready) begin
        exp_q.push_back(golden(a, b));
        sent++;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("t6_sent", 32'(sent), 32'd1000);
    out_ready = 1'b1;
    wait_drain("t6");
    @(posedge clk); #1;
    check("t6_busy_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
